// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: register hold/flush,
// PC enable, EX forwarding selects, data-memory wait FSM and perf counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             ID_redirect,
  input  logic [4:0]       EX_rs,
  input  logic [4:0]       EX_rt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_write_reg,
  input  logic             MEM_RegWr,
  input  logic [4:0]       MEM_write_reg,
  input  logic [1:0]       MEM_MemtoReg,
  input  logic             MEM_access,
  input  logic             WB_RegWr,
  input  logic [4:0]       WB_write_reg,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_we,
  output logic             pc_redirect_en,
  output logic             IF_ID_hold,
  output logic             IF_ID_flush,
  output logic             ID_EX_hold,
  output logic             ID_EX_flush,
  output logic             EX_MEM_hold,
  output logic             MEM_WB_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_timeout
);

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        freeze, lu, set_err;

  // Reset forces the RUN view so combinational outputs are sane before the edge.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    freeze       = 1'b0;
    dmem_req     = 1'b0;
    set_err      = 1'b0;
    if (reset || state == RUN) begin
      if (MEM_access) begin
        dmem_req     = 1'b1;
        freeze       = 1'b1;
        state_nxt    = WAIT;
        wait_cnt_nxt = 16'd0;
      end
    end else if (dmem_ready) begin
      state_nxt    = RUN;
      wait_cnt_nxt = 16'd0;
    end else begin
      freeze = 1'b1;
      // counter parks at the timeout value so it can never wrap
      if (wait_cnt != TMO) wait_cnt_nxt = wait_cnt + 16'd1;
      set_err = (wait_cnt >= TMO - 16'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= 16'd0;
      err_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (set_err) err_timeout <= 1'b1;
    end
  end

  assign lu = EX_MemRead && (EX_write_reg != 5'd0) &&
              ((ID_uses_rs && EX_write_reg == ID_rs) ||
               (ID_uses_rt && EX_write_reg == ID_rt));

  always_comb begin
    pc_we          = 1'b1;
    pc_redirect_en = 1'b0;
    IF_ID_hold     = 1'b0;
    IF_ID_flush    = 1'b0;
    ID_EX_hold     = 1'b0;
    ID_EX_flush    = 1'b0;
    EX_MEM_hold    = 1'b0;
    MEM_WB_flush   = 1'b0;
    if (freeze) begin
      pc_we        = 1'b0;
      IF_ID_hold   = 1'b1;
      ID_EX_hold   = 1'b1;
      EX_MEM_hold  = 1'b1;
      MEM_WB_flush = 1'b1;
    end else if (lu) begin
      pc_we       = 1'b0;
      IF_ID_hold  = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (ID_redirect) begin
      pc_redirect_en = 1'b1;
      IF_ID_flush    = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] r,
    input logic       mem_wr,
    input logic [4:0] mem_reg,
    input logic [1:0] mem_mtr,
    input logic       wb_wr,
    input logic [4:0] wb_reg
  );
    if (r == 5'd0)                 return 2'b00;
    if (mem_wr && mem_reg == r)    return (mem_mtr == 2'b10) ? 2'b11 : 2'b10;
    if (wb_wr && wb_reg == r)      return 2'b01;
    return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(EX_rs, MEM_RegWr, MEM_write_reg, MEM_MemtoReg, WB_RegWr, WB_write_reg);
  assign fwd_b = fwd_sel(EX_rt, MEM_RegWr, MEM_write_reg, MEM_MemtoReg, WB_RegWr, WB_write_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((freeze || lu) && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (pc_redirect_en && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + randomized bench for pipe_hazard_ctrl against a cycle-level
// behavioural model of the pipeline-control rules.
module tb_pipe_hazard_ctrl;
  localparam int TMO  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] ID_rs, ID_rt, EX_rs, EX_rt, EX_write_reg, MEM_write_reg, WB_write_reg;
  logic ID_uses_rs, ID_uses_rt, ID_redirect, EX_MemRead, MEM_RegWr, MEM_access;
  logic WB_RegWr, dmem_ready;
  logic [1:0] MEM_MemtoReg;
  logic dmem_req, pc_we, pc_redirect_en, IF_ID_hold, IF_ID_flush, ID_EX_hold;
  logic ID_EX_flush, EX_MEM_hold, MEM_WB_flush, err_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_redirect(ID_redirect), .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_MemRead(EX_MemRead),
    .EX_write_reg(EX_write_reg), .MEM_RegWr(MEM_RegWr), .MEM_write_reg(MEM_write_reg),
    .MEM_MemtoReg(MEM_MemtoReg), .MEM_access(MEM_access), .WB_RegWr(WB_RegWr),
    .WB_write_reg(WB_write_reg), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .pc_we(pc_we), .pc_redirect_en(pc_redirect_en), .IF_ID_hold(IF_ID_hold),
    .IF_ID_flush(IF_ID_flush), .ID_EX_hold(ID_EX_hold), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_hold(EX_MEM_hold), .MEM_WB_flush(MEM_WB_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // model: is a memory access outstanding, how long, and the sticky/counter state
  bit m_wait;
  int m_wcnt;
  bit m_err;
  int m_stall, m_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] r);
    bit mem_hit, wb_hit;
    mem_hit = MEM_RegWr && MEM_write_reg == r;
    wb_hit  = WB_RegWr && WB_write_reg == r;
    if (r == 0) return 2'd0;
    if (mem_hit) return (MEM_MemtoReg == 2'b10) ? 2'd3 : 2'd2;
    return wb_hit ? 2'd1 : 2'd0;
  endfunction

  task automatic idle();
    reset = 0; ID_rs = 0; ID_rt = 0; ID_uses_rs = 0; ID_uses_rt = 0; ID_redirect = 0;
    EX_rs = 0; EX_rt = 0; EX_MemRead = 0; EX_write_reg = 0; MEM_RegWr = 0;
    MEM_write_reg = 0; MEM_MemtoReg = 0; MEM_access = 0; WB_RegWr = 0;
    WB_write_reg = 0; dmem_ready = 0;
  endtask

  // Check every output for the current inputs, clock once, advance the model.
  task automatic cycle();
    bit waiting, frz, lu, rd;
    #1;
    waiting = m_wait && !reset;
    frz = waiting ? !dmem_ready : MEM_access;
    lu  = EX_MemRead && EX_write_reg != 0 &&
          ((ID_uses_rs && EX_write_reg == ID_rs) || (ID_uses_rt && EX_write_reg == ID_rt));
    rd  = ID_redirect && !frz && !lu;
    chk("dmem_req",       dmem_req,       !waiting && MEM_access);
    chk("pc_we",          pc_we,          !(frz || lu));
    chk("IF_ID_hold",     IF_ID_hold,     frz || lu);
    chk("IF_ID_flush",    IF_ID_flush,    rd);
    chk("ID_EX_hold",     ID_EX_hold,     frz);
    chk("ID_EX_flush",    ID_EX_flush,    lu && !frz);
    chk("EX_MEM_hold",    EX_MEM_hold,    frz);
    chk("MEM_WB_flush",   MEM_WB_flush,   frz);
    chk("pc_redirect_en", pc_redirect_en, rd);
    chk("fwd_a",          fwd_a,          ref_fwd(EX_rs));
    chk("fwd_b",          fwd_b,          ref_fwd(EX_rt));
    chk("stall_cnt",      stall_cnt,      m_stall);
    chk("flush_cnt",      flush_cnt,      m_flush);
    chk("err_timeout",    err_timeout,    m_err);
    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (frz || lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (rd)        m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (!m_wait) begin
        if (MEM_access) begin m_wait = 1; m_wcnt = 0; end
      end else if (dmem_ready) begin
        m_wait = 0; m_wcnt = 0;
      end else begin
        m_wcnt++;
        if (m_wcnt >= TMO) m_err = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); reset = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    idle(); reset = 1;
    m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); @(negedge clk);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_flush", flush_cnt, 0);
    chk("reset_err",   err_timeout, 0);
    reset = 0;

    // load-use on rs
    EX_MemRead = 1; EX_write_reg = 8; ID_rs = 8; ID_uses_rs = 1;
    #1 chk("lu_pc_we", pc_we, 0); chk("lu_id_ex_flush", ID_EX_flush, 1);
    cycle();
    chk("lu_stall_1", stall_cnt, 1);
    EX_MemRead = 0;
    cycle();
    // load-use suppressed when destination is r0
    EX_MemRead = 1; EX_write_reg = 0; ID_rs = 0;
    cycle();
    idle();

    // memory wait, ready at cycle 3
    do_reset();
    MEM_access = 1;
    #1 chk("mw_req_c0", dmem_req, 1);
    cycle(); cycle(); cycle();
    dmem_ready = 1;
    #1 chk("mw_release_c3", MEM_WB_flush, 0);
    cycle();
    chk("mw_stall_3", stall_cnt, 3);
    // back-to-back access starts a fresh request
    dmem_ready = 0;
    #1 chk("mw_b2b_req", dmem_req, 1);
    cycle();
    dmem_ready = 1; MEM_access = 0;
    cycle();
    idle();

    // redirect loses to load-use, then wins alone
    do_reset();
    ID_redirect = 1; EX_MemRead = 1; EX_write_reg = 9; ID_rt = 9; ID_uses_rt = 1;
    cycle();
    chk("rd_vs_lu_flush", flush_cnt, 0);
    EX_MemRead = 0;
    cycle();
    chk("rd_alone_flush", flush_cnt, 1);
    idle();

    // forwarding priority
    EX_rs = 5; EX_rt = 6; MEM_RegWr = 1; MEM_write_reg = 5; WB_RegWr = 1; WB_write_reg = 5;
    #1 chk("fwd_mem", fwd_a, 2'b10); chk("fwd_b_none", fwd_b, 2'b00);
    cycle();
    MEM_MemtoReg = 2'b10; cycle();
    #1 chk("fwd_link", fwd_a, 2'b11);
    MEM_RegWr = 0; WB_write_reg = 6; EX_rt = 6; cycle();
    EX_rs = 0; MEM_RegWr = 1; MEM_write_reg = 0; WB_write_reg = 0;
    #1 chk("fwd_r0", fwd_a, 2'b00);
    cycle();
    idle();

    // timeout after TMO wait cycles, sticky, cleared only by reset
    do_reset();
    MEM_access = 1; cycle();
    MEM_access = 0;
    for (int i = 0; i < TMO - 1; i++) cycle();
    chk("tmo_not_yet", err_timeout, 0);
    cycle();
    chk("tmo_set", err_timeout, 1);
    cycle();
    dmem_ready = 1; cycle();
    dmem_ready = 0;
    chk("tmo_sticky", err_timeout, 1);
    MEM_access = 1; cycle();
    MEM_access = 0; cycle();
    do_reset();
    chk("tmo_reset_err", err_timeout, 0);
    chk("tmo_reset_stall", stall_cnt, 0);
    cycle();

    // stall counter saturation
    EX_MemRead = 1; EX_write_reg = 3; ID_rs = 3; ID_uses_rs = 1;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_stall", stall_cnt, CMAX);
    idle();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 49) == 0);
      ID_rs         = 5'($urandom_range(0, 7));
      ID_rt         = 5'($urandom_range(0, 7));
      ID_uses_rs    = 1'($urandom_range(0, 1));
      ID_uses_rt    = 1'($urandom_range(0, 1));
      ID_redirect   = ($urandom_range(0, 2) == 0);
      EX_rs         = 5'($urandom_range(0, 7));
      EX_rt         = 5'($urandom_range(0, 7));
      EX_MemRead    = ($urandom_range(0, 2) == 0);
      EX_write_reg  = 5'($urandom_range(0, 7));
      MEM_RegWr     = 1'($urandom_range(0, 1));
      MEM_write_reg = 5'($urandom_range(0, 7));
      MEM_MemtoReg  = 2'($urandom_range(0, 3));
      MEM_access    = ($urandom_range(0, 3) == 0);
      WB_RegWr      = 1'($urandom_range(0, 1));
      WB_write_reg  = 5'($urandom_range(0, 7));
      dmem_ready    = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
